// File: rtl/key_pkg.sv
// Shared constants for the keyboard FIFO: code/word widths, status-word bit
// positions for the default depth, and CPU-visible register offsets.
package key_pkg;
  localparam int KEY_CODE_W   = 7;
  localparam int KEY_DATA_W   = 32;
  localparam int KEY_DEPTH    = 8;
  localparam int KEY_CNT_W    = $clog2(KEY_DEPTH) + 1;

  // status = {zeros, ovf, full, empty, count}
  localparam int ST_CNT_LSB   = 0;
  localparam int ST_EMPTY     = KEY_CNT_W;
  localparam int ST_FULL      = KEY_CNT_W + 1;
  localparam int ST_OVF       = KEY_CNT_W + 2;

  localparam int KEY_DATA_OFS = 0;
  localparam int KEY_STAT_OFS = 4;

  function automatic logic [KEY_DATA_W-1:0] zext_code(input logic [KEY_CODE_W-1:0] c);
    return {{(KEY_DATA_W-KEY_CODE_W){1'b0}}, c};
  endfunction
endpackage

// File: rtl/key_fifo_mem.sv
// DEPTH x W storage for queued key codes: one write port, one async read port.
// Contents are not reset; the controller's pointers/count define validity.
module key_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 7,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/key_fifo_ctrl.sv
// Key-code FIFO for the CPU: same-key repeat filter, FIFO control, registered
// zero-extended read data, polled status word and a level interrupt.
module key_fifo_ctrl
  import key_pkg::*;
#(
  parameter int DEPTH      = KEY_DEPTH,
  parameter int CODE_W     = KEY_CODE_W,
  parameter int DATA_W     = KEY_DATA_W,
  parameter int REPEAT_GAP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [CODE_W-1:0] key_code,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] status,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (REPEAT_GAP > 0) ? $clog2(REPEAT_GAP + 1) : 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic [RW-1:0]     rpt_cnt_q, rpt_cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              irq_q;

  logic              empty, full, filtered, accept, push, pop;
  logic [CODE_W-1:0] mem_rdata;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign filtered = (REPEAT_GAP > 0) && (key_code == last_code_q) && (rpt_cnt_q != '0);
  assign accept   = key_valid && !filtered;
  assign pop      = rd_en && !empty;
  // A full FIFO still takes a new code when the CPU pops in the same cycle:
  // the write lands in the slot being freed, whose old value is read first.
  assign push     = accept && (!full || rd_en);

  key_fifo_mem #(.DEPTH(DEPTH), .W(CODE_W)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (key_code),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    last_code_d = last_code_q;
    rpt_cnt_d   = (rpt_cnt_q != '0) ? rpt_cnt_q - RW'(1) : '0;
    ovf_d       = ovf_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    count_d     = count_q;

    if (accept) begin
      last_code_d = key_code;
      rpt_cnt_d   = RW'(REPEAT_GAP);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Overflow set wins over a same-cycle software clear.
    if (accept && full && !rd_en) ovf_d = 1'b1;
    else if (clr_ovf)             ovf_d = 1'b0;

    if (pop) begin
      rd_data_d  = DATA_W'(mem_rdata);
      rd_valid_d = 1'b1;
    end else if (rd_en) begin
      rd_data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_code_q <= '0;
      rpt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_code_q <= last_code_d;
      rpt_cnt_q   <= rpt_cnt_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      irq_q       <= !empty;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;
  assign status   = DATA_W'({ovf_q, full, empty, count_q});
endmodule

// File: tb/tb_key_fifo_ctrl.sv
// Randomised + directed bench for key_fifo_ctrl against a queue-based model;
// popped words are scoreboarded and checked by an independent monitor.
module tb_key_fifo_ctrl;
  import key_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [6:0]  key_code = '0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [31:0] rd_data, status;
  logic        rd_valid, irq;

  key_fifo_ctrl #(.DEPTH(DEPTH), .CODE_W(7), .DATA_W(32), .REPEAT_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid),
    .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue contents plus the time of the last accepted key.
  int          mq[$];
  logic [31:0] expq[$];
  bit          m_ovf, m_rdv, m_irq, init;
  int          m_last_code, m_last_t, cyc;
  logic [31:0] m_rd_data;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[ST_CNT_LSB +: KEY_CNT_W] = KEY_CNT_W'(mq.size());
    s[ST_EMPTY] = (mq.size() == 0);
    s[ST_FULL]  = (mq.size() == DEPTH);
    s[ST_OVF]   = m_ovf;
    return s;
  endfunction

  task automatic model_step(input bit r, input bit kv, input int kc, input bit re, input bit co);
    bit was_empty, was_full, filt, acc;
    cyc++;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_rdv = 0; m_irq = 0; m_rd_data = '0;
      m_last_code = 0; m_last_t = -100000;
      return;
    end
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    // Same code is suppressed for GAP cycles after the last accepted one.
    filt = (GAP > 0) && kv && (kc == m_last_code) && (cyc - m_last_t <= GAP);
    acc  = kv && !filt;
    m_rdv = 0;
    if (re && !was_empty) begin
      m_rd_data = zext_code(7'(mq.pop_front()));
      m_rdv = 1;
      expq.push_back(m_rd_data);
    end else if (re) begin
      m_rd_data = '0;
    end
    if (acc && (!was_full || re)) mq.push_back(kc);
    if (acc && was_full && !re) m_ovf = 1;
    else if (co)                m_ovf = 0;
    if (acc) begin
      m_last_code = kc;
      m_last_t = cyc;
    end
    m_irq = !was_empty;
  endtask

  task automatic step(input bit r, input bit kv, input int kc, input bit re, input bit co);
    @(negedge clk);
    if (init) begin
      cmp("status", status, exp_status());
      cmp("irq", {31'd0, irq}, {31'd0, m_irq});
      cmp("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
      cmp("rd_data", rd_data, m_rd_data);
    end
    rst = r; key_valid = kv; key_code = 7'(kc); rd_en = re; clr_ovf = co;
    model_step(r, kv, kc, re, co);
    init = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic push(input int kc);
    step(0, 1, kc, 0, 0);
  endtask

  task automatic pop();
    step(0, 0, 0, 1, 0);
  endtask

  // Monitor: every rd_valid must consume the oldest expected popped word.
  bit done = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      if (init && rd_valid) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL monitor_spurious cycle=%0d got=0x%08h expected=no pop", cyc, rd_data);
        end else begin
          cmp("monitor_pop", rd_data, expq.pop_front());
        end
      end
    end
  end

  initial begin
    cyc = 0; init = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(1);
    cmp("reset_status", status, 32'h0000_0010);

    // 1: single push, pop
    push(8'h41); pop(); idle(2);
    // 2: three pushes, three pops
    push(8'h12); push(8'h34); push(8'h7F); pop(); pop(); pop(); idle(2);

    // 3: repeat filter
    step(1, 0, 0, 0, 0);
    push(8'h20); idle(4); push(8'h20); idle(14); push(8'h20); idle(1);
    cmp("filter_count", {28'd0, status[3:0]}, 32'd2);
    pop(); pop(); idle(1);
    step(1, 0, 0, 0, 0);
    push(8'h20); push(8'h21); idle(1);
    cmp("filter_other", {28'd0, status[3:0]}, 32'd2);
    pop(); pop(); idle(1);

    // 4: fill, overflow, full+pop, sticky overflow vs clear
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) push(8'h50 + i);
    push(8'h60); idle(1);
    cmp("ovf_full", status, 32'h0000_0068);
    step(0, 1, 8'h61, 1, 0);
    step(0, 1, 8'h62, 0, 1);
    idle(1);
    cmp("ovf_sticky", {31'd0, status[ST_OVF]}, 32'd1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) pop();
    idle(2);

    // 5: pop on empty with simultaneous push
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h05, 1, 0);
    idle(2);
    pop(); idle(1);

    // 6: wrapped pointers, then reset mid-stream
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin push(8'h30 + i); pop(); end
    for (int i = 0; i < 4; i++) push(8'h10 + i);
    step(1, 1, 8'h70, 1, 0);
    idle(1);
    cmp("rst_mid_status", status, 32'h0000_0010);

    // Random phase: small code alphabet exercises the repeat filter.
    for (int b = 0; b < 30; b++) begin
      int rd_pct, kv_pct;
      rd_pct = $urandom_range(10, 70);
      kv_pct = $urandom_range(20, 90);
      for (int i = 0; i < 25; i++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < kv_pct),
             $urandom_range(0, 5),
             ($urandom_range(0, 99) < rd_pct),
             ($urandom_range(0, 19) == 0));
      end
    end
    idle(3);
    cmp("scoreboard_drained", 32'(expq.size()), 32'd0);
    done = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
